seg7_scan_driver: RTL

//   Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.

---
 rtl/seg7_scan_driver.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with shadowed digit data.
// Optional leading-zero blanking is compiled in with `define SEG_LZB_EN.
module seg7_scan_driver #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] data,
    input  logic [DIGITS-1:0]   dp_mask,
    input  logic [DIGITS-1:0]   en_mask,
    output logic [7:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic                wrap
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] data_q, data_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
    logic [DIGITS-1:0]   en_q, en_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                wrap_q, wrap_d;
    logic [DIGITS-1:0]   lz_blank;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'h40;
            4'h1: code = 7'h79;
            4'h2: code = 7'h24;
            4'h3: code = 7'h30;
            4'h4: code = 7'h19;
            4'h5: code = 7'h12;
            4'h6: code = 7'h02;
            4'h7: code = 7'h78;
            4'h8: code = 7'h00;
            4'h9: code = 7'h10;
            4'hA: code = 7'h08;
            4'hB: code = 7'h03;
            4'hC: code = 7'h46;
            4'hD: code = 7'h21;
            4'hE: code = 7'h06;
            default: code = 7'h0E;
        endcase
        return code;
    endfunction

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (idx_q == IDX_MAX) begin
                idx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        data_d = data_q;
        dp_d   = dp_q;
        en_d   = en_q;
        if (load) begin
            data_d = data;
            dp_d   = dp_mask;
            en_d   = en_mask;
        end
    end

`ifdef SEG_LZB_EN
    // Walk from the top digit down; blanking continues while every enabled
    // nibble seen so far is zero and no decimal point has been reached.
    always_comb begin
        logic        zero_run;
        int unsigned j;
        lz_blank = '0;
        zero_run = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            j = DIGITS - 1 - k;
            zero_run = zero_run & ~dp_q[j] & (~en_q[j] | (data_q[4*j +: 4] == 4'h0));
            lz_blank[j] = zero_run && (j != 0);
        end
    end
`else
    always_comb begin
        lz_blank = '0;
    end
`endif

    // Outputs follow the upcoming idx with the current shadow, so a load on a
    // digit-change edge still shows the old nibble for that one cycle.
    always_comb begin
        seg_d = 8'hFF;
        an_d  = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i) && en_q[i] && !lz_blank[i]) begin
                an_d[i] = 1'b0;
                seg_d   = {~dp_q[i], hex7(data_q[4*i +: 4])};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
            dp_q   <= '0;
            en_q   <= '0;
            seg_q  <= 8'hFF;
            an_q   <= '1;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            data_q <= data_d;
            dp_q   <= dp_d;
            en_q   <= en_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            wrap_q <= wrap_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign wrap = wrap_q;

endmodule
